mem_request_unit: RTL

- Arbitrates the CPU's instruction-fetch port and data load/store port onto a single shared RAM port.
- Sits between the pc/control datapath and external RAM.
- Holds a one-entry fetch buffer so that re-fetching the same instruction address skips RAM.
- Generalised over address/data width and RAM handshake timing, with a watchdog timeout.

---
 rtl/mem_request_unit_pkg.sv | 32 +++
 rtl/mem_fetch_buffer.sv | 51 +++++
 rtl/mem_request_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_request_unit_pkg.sv
// Shared types for the memory request unit: controller states and request classification.
package mem_request_unit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        FETCH,
        HIT
    } state_e;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_READ,
        REQ_WRITE,
        REQ_FETCH
    } req_e;

    // Data port beats fetch; a simultaneous read+write is treated as a write.
    function automatic req_e classify_req(input logic d_ren, input logic d_wen, input logic i_req);
        if (d_wen) begin
            return REQ_WRITE;
        end
        if (d_ren) begin
            return REQ_READ;
        end
        if (i_req) begin
            return REQ_FETCH;
        end
        return REQ_NONE;
    endfunction

endpackage

// File: rtl/mem_fetch_buffer.sv
// One-entry instruction fetch buffer: remembers the last fetched {addr,data} and
// drops it when a store lands on the same address.
module mem_fetch_buffer #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit_c,
    output logic [DATA_W-1:0] rdata,
    input  logic              fill,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_addr
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (fill) begin
            valid_d = 1'b1;
            addr_d  = fill_addr;
            data_d  = fill_data;
        end else if (flush && valid_q && (flush_addr == addr_q)) begin
            valid_d = 1'b0;
        end
    end

    assign hit_c = valid_q && (lookup_addr == addr_q);
    assign rdata = data_q;

endmodule

// File: rtl/mem_request_unit.sv
// Arbitrates the instruction-fetch and data ports onto one RAM port, with an
// optional one-entry fetch buffer and a watchdog on the RAM handshake.
module mem_request_unit
    import mem_request_unit_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned FBUF_EN = 1
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_ren,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_ren,
    output logic              ram_wen,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ready,
    output logic              err
);

    localparam int unsigned CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned CNT_LAST = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;

    state_e            state_q, state_d;
    req_e              req_q, req_d;
    req_e              req_c;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_c;

    logic              i_ready_q, i_ready_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic              d_ready_q, d_ready_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              ram_ren_q, ram_ren_d;
    logic              ram_wen_q, ram_wen_d;
    logic              err_q, err_d;

    logic              fb_hit_c;
    logic [DATA_W-1:0] fb_data;
    logic              fb_fill_c;
    logic              fb_flush_c;

    generate
        if (FBUF_EN != 0) begin : g_fbuf
            mem_fetch_buffer #(
                .ADDR_W (ADDR_W),
                .DATA_W (DATA_W)
            ) u_fbuf (
                .clk         (clk),
                .nRST        (nRST),
                .lookup_addr (i_addr),
                .hit_c       (fb_hit_c),
                .rdata       (fb_data),
                .fill        (fb_fill_c),
                .fill_addr   (ram_addr_q),
                .fill_data   (ram_rdata),
                .flush       (fb_flush_c),
                .flush_addr  (ram_addr_q)
            );
        end else begin : g_no_fbuf
            assign fb_hit_c = 1'b0;
            assign fb_data  = '0;
        end
    endgenerate

    assign req_c     = classify_req(d_ren, d_wen, i_req);
    assign timeout_c = (TIMEOUT != 0) && (cnt_q == CNT_W'(CNT_LAST));

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            req_q       <= REQ_NONE;
            cnt_q       <= '0;
            i_ready_q   <= 1'b0;
            i_rdata_q   <= '0;
            d_ready_q   <= 1'b0;
            d_rdata_q   <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_ren_q   <= 1'b0;
            ram_wen_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            i_ready_q   <= i_ready_d;
            i_rdata_q   <= i_rdata_d;
            d_ready_q   <= d_ready_d;
            d_rdata_q   <= d_rdata_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_ren_q   <= ram_ren_d;
            ram_wen_q   <= ram_wen_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        cnt_d       = '0;
        i_ready_d   = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_ready_d   = 1'b0;
        d_rdata_d   = d_rdata_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_ren_d   = ram_ren_q;
        ram_wen_d   = ram_wen_q;
        err_d       = 1'b0;
        fb_fill_c   = 1'b0;
        fb_flush_c  = 1'b0;

        case (state_q)
            IDLE: begin
                case (req_c)
                    REQ_READ, REQ_WRITE: begin
                        state_d     = DATA;
                        req_d       = req_c;
                        ram_addr_d  = d_addr;
                        ram_wdata_d = d_wdata;
                        ram_ren_d   = (req_c == REQ_READ);
                        ram_wen_d   = (req_c == REQ_WRITE);
                        err_d       = d_ren & d_wen;
                    end
                    REQ_FETCH: begin
                        if (fb_hit_c) begin
                            state_d   = HIT;
                            i_ready_d = 1'b1;
                            i_rdata_d = fb_data;
                        end else begin
                            state_d     = FETCH;
                            req_d       = REQ_FETCH;
                            ram_addr_d  = i_addr;
                            ram_wdata_d = '0;
                            ram_ren_d   = 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end

            // ram_ready wins over a watchdog expiry in the same cycle
            DATA, FETCH: begin
                if (ram_ready || timeout_c) begin
                    state_d   = IDLE;
                    req_d     = REQ_NONE;
                    ram_ren_d = 1'b0;
                    ram_wen_d = 1'b0;
                    err_d     = !ram_ready;
                    if (state_q == DATA) begin
                        d_ready_d = 1'b1;
                        if (!ram_ready) begin
                            d_rdata_d = '0;
                        end else if (req_q == REQ_READ) begin
                            d_rdata_d = ram_rdata;
                        end
                        // an aborted store may still have landed, so flush on either outcome
                        fb_flush_c = (req_q == REQ_WRITE);
                    end else begin
                        i_ready_d = 1'b1;
                        i_rdata_d = ram_ready ? ram_rdata : '0;
                        fb_fill_c = ram_ready;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            HIT: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign i_ready   = i_ready_q;
    assign i_rdata   = i_rdata_q;
    assign d_ready   = d_ready_q;
    assign d_rdata   = d_rdata_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_ren   = ram_ren_q;
    assign ram_wen   = ram_wen_q;
    assign err       = err_q;

endmodule
